// File: rtl/operand_bypass_unit_pkg.sv
// Shared widths, writer-tag layout and tag helpers for the operand bypass unit.
// The tag pipeline and both operand resolvers rely on the same producer-match rule.
package operand_bypass_unit_pkg;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned TW = 2;

   localparam logic [TW-1:0] TUSE_NONE = TW'(3);

   typedef enum logic [1:0] {
      SRC_RF = 2'd0,
      SRC_E  = 2'd1,
      SRC_M  = 2'd2,
      SRC_W  = 2'd3
   } src_e;

   typedef struct packed {
      logic          valid;
      logic          we;
      logic [AW-1:0] dst;
      logic [TW-1:0] tnew;
   } tag_t;

   // A stage produces r when it holds a valid GPR writer targeting r; $0 is never produced.
   function automatic logic produces(tag_t t, logic [AW-1:0] r);
      return t.valid && t.we && (t.dst == r) && (r != AW'(0));
   endfunction

   // Tag as seen one stage further down: tnew counts down and saturates at zero.
   function automatic tag_t advance(tag_t t);
      tag_t n;
      n = t;
      if (t.tnew != TW'(0)) begin
         n.tnew = t.tnew - TW'(1);
      end
      return n;
   endfunction

   // E-stage operand: only M and W can still hold a producer older than the E instruction.
   function automatic logic [DW-1:0] resolve_mw(logic [AW-1:0] r, tag_t tm, tag_t tw,
                                                logic [DW-1:0] fm, logic [DW-1:0] fw,
                                                logic [DW-1:0] held);
      logic [DW-1:0] v;
      v = held;
      if (produces(tm, r)) begin
         if (tm.tnew == TW'(0)) begin
            v = fm;
         end
      end else if (produces(tw, r)) begin
         if (tw.tnew == TW'(0)) begin
            v = fw;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/operand_bypass_unit_fwd_select.sv
// One D-stage operand: finds the nearest in-flight producer (E > M > W),
// raises a stall term when it cannot be ready in time, and muxes the forward source.
module operand_bypass_unit_fwd_select
   import operand_bypass_unit_pkg::*;
(
   input  logic [AW-1:0] r,
   input  logic [TW-1:0] tuse,
   input  tag_t          tag_e,
   input  tag_t          tag_m,
   input  tag_t          tag_w,
   input  logic [DW-1:0] fwd_e,
   input  logic [DW-1:0] fwd_m,
   input  logic [DW-1:0] fwd_w,
   input  logic [DW-1:0] rf_rd,
   output logic [DW-1:0] val_c,
   output logic          stall_c
);

   src_e          src_c;
   logic [TW-1:0] ptnew_c;

   // Nearest producer: the youngest older instruction holds the architecturally current value.
   always_comb begin
      src_c   = SRC_RF;
      ptnew_c = TW'(0);
      if (produces(tag_e, r)) begin
         src_c   = SRC_E;
         ptnew_c = tag_e.tnew;
      end else if (produces(tag_m, r)) begin
         src_c   = SRC_M;
         ptnew_c = tag_m.tnew;
      end else if (produces(tag_w, r)) begin
         src_c   = SRC_W;
         ptnew_c = tag_w.tnew;
      end
   end

   // A producer not yet ready falls back to rf_rd; the E-stage re-resolve repairs it later.
   always_comb begin
      stall_c = (src_c != SRC_RF) && (ptnew_c > tuse);
      val_c   = rf_rd;
      if (ptnew_c == TW'(0)) begin
         unique case (src_c)
            SRC_E:   val_c = fwd_e;
            SRC_M:   val_c = fwd_m;
            SRC_W:   val_c = fwd_w;
            default: val_c = rf_rd;
         endcase
      end
   end

endmodule

// File: rtl/operand_bypass_unit.sv
// Decode-side GRF reader: writer-tag pipeline (E/M/W), RAW stall/forward resolution,
// D/E operand register, and GRF write-port drive from the W-stage tag.
module operand_bypass_unit
   import operand_bypass_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          d_valid,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic          d_we,
   input  logic [AW-1:0] d_dst,
   input  logic [TW-1:0] d_tnew,
   output logic [AW-1:0] rf_a1,
   output logic [AW-1:0] rf_a2,
   input  logic [DW-1:0] rf_rd1,
   input  logic [DW-1:0] rf_rd2,
   input  logic [DW-1:0] fwd_e,
   input  logic [DW-1:0] fwd_m,
   input  logic [DW-1:0] fwd_w,
   output logic          stall,
   output logic [DW-1:0] d_rs_val,
   output logic [DW-1:0] d_rt_val,
   output logic [DW-1:0] e_rs_val,
   output logic [DW-1:0] e_rt_val,
   output logic          rf_we,
   output logic [AW-1:0] rf_a3
);

   tag_t          tag_e_q, tag_m_q, tag_w_q;
   logic [DW-1:0] e_rs_q, e_rt_q;
   logic [AW-1:0] e_rs_addr_q, e_rt_addr_q;
   logic          rs_stall_c, rt_stall_c;

   assign rf_a1 = d_rs;
   assign rf_a2 = d_rt;

   operand_bypass_unit_fwd_select u_fwd_rs (
      .r       (d_rs),
      .tuse    (d_tuse_rs),
      .tag_e   (tag_e_q),
      .tag_m   (tag_m_q),
      .tag_w   (tag_w_q),
      .fwd_e   (fwd_e),
      .fwd_m   (fwd_m),
      .fwd_w   (fwd_w),
      .rf_rd   (rf_rd1),
      .val_c   (d_rs_val),
      .stall_c (rs_stall_c)
   );

   operand_bypass_unit_fwd_select u_fwd_rt (
      .r       (d_rt),
      .tuse    (d_tuse_rt),
      .tag_e   (tag_e_q),
      .tag_m   (tag_m_q),
      .tag_w   (tag_w_q),
      .fwd_e   (fwd_e),
      .fwd_m   (fwd_m),
      .fwd_w   (fwd_w),
      .rf_rd   (rf_rd2),
      .val_c   (d_rt_val),
      .stall_c (rt_stall_c)
   );

   assign stall = rs_stall_c | rt_stall_c;

   // Writer tags always advance; a stalled or empty D slot enters E as an all-zero bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_e_q <= '0;
         tag_m_q <= '0;
         tag_w_q <= '0;
      end else begin
         tag_m_q <= advance(tag_e_q);
         tag_w_q <= advance(tag_m_q);
         if (stall || !d_valid) begin
            tag_e_q <= '0;
         end else begin
            tag_e_q <= '{valid: 1'b1, we: d_we, dst: d_dst, tnew: d_tnew};
         end
      end
   end

   // D/E operand register; address zero on a bubble so nothing can forward into it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_rs_q      <= '0;
         e_rt_q      <= '0;
         e_rs_addr_q <= '0;
         e_rt_addr_q <= '0;
      end else if (stall) begin
         e_rs_q      <= '0;
         e_rt_q      <= '0;
         e_rs_addr_q <= '0;
         e_rt_addr_q <= '0;
      end else begin
         e_rs_q      <= d_rs_val;
         e_rt_q      <= d_rt_val;
         e_rs_addr_q <= d_rs;
         e_rt_addr_q <= d_rt;
      end
   end

   assign e_rs_val = resolve_mw(e_rs_addr_q, tag_m_q, tag_w_q, fwd_m, fwd_w, e_rs_q);
   assign e_rt_val = resolve_mw(e_rt_addr_q, tag_m_q, tag_w_q, fwd_m, fwd_w, e_rt_q);

   // There is no write-through inside the GRF, which is why W forwarding above is required.
   assign rf_we = tag_w_q.valid && tag_w_q.we && (tag_w_q.dst != AW'(0));
   assign rf_a3 = tag_w_q.dst;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed scenario bench for operand_bypass_unit with hand-computed expectations.
module tb_operand_bypass_unit;
   import operand_bypass_unit_pkg::*;

   logic          clk;
   logic          reset;
   logic          d_valid;
   logic [AW-1:0] d_rs, d_rt, d_dst;
   logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic          d_we;
   logic [AW-1:0] rf_a1, rf_a2, rf_a3;
   logic [DW-1:0] rf_rd1, rf_rd2, fwd_e, fwd_m, fwd_w;
   logic          stall, rf_we;
   logic [DW-1:0] d_rs_val, d_rt_val, e_rs_val, e_rt_val;

   int checks   = 0;
   int failures = 0;

   operand_bypass_unit dut (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_we(d_we), .d_dst(d_dst), .d_tnew(d_tnew),
      .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .fwd_e(fwd_e), .fwd_m(fwd_m), .fwd_w(fwd_w),
      .stall(stall), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
      .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .rf_we(rf_we), .rf_a3(rf_a3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_valid   = 1'b0;
      d_rs      = '0;
      d_rt      = '0;
      d_tuse_rs = TUSE_NONE;
      d_tuse_rt = TUSE_NONE;
      d_we      = 1'b0;
      d_dst     = '0;
      d_tnew    = '0;
   endtask

   task automatic issue(input logic [AW-1:0] rs, input logic [TW-1:0] trs,
                        input logic [AW-1:0] rt, input logic [TW-1:0] trt,
                        input logic we, input logic [AW-1:0] dst, input logic [TW-1:0] tnew);
      d_valid   = 1'b1;
      d_rs      = rs;
      d_tuse_rs = trs;
      d_rt      = rt;
      d_tuse_rt = trt;
      d_we      = we;
      d_dst     = dst;
      d_tnew    = tnew;
   endtask

   task automatic flush();
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      idle();
      rf_rd1 = 32'h1111_1111; rf_rd2 = 32'h2222_2222;
      fwd_e = 32'hE0; fwd_m = 32'hD0; fwd_w = 32'hC0;
      reset = 1'b0;
      #12;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
      checks++; if (e_rs_val !== 32'h0) begin failures++; $display("FAIL reset_e_rs got=%h exp=0", e_rs_val); end
      checks++; if (e_rt_val !== 32'h0) begin failures++; $display("FAIL reset_e_rt got=%h exp=0", e_rt_val); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_alu_fwd_m();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd8, 2'd1);
      tick();
      issue(5'd8, 2'd1, 5'd0, TUSE_NONE, 1'b1, 5'd10, 2'd1);
      rf_rd1 = 32'h5555; rf_rd2 = 32'h0; fwd_e = 32'hEEEE; fwd_m = 32'h1234; fwd_w = 32'hCCCC;
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall); end
      checks++; if (rf_a1 !== 5'd8) begin failures++; $display("FAIL alu_rf_a1 got=%0d exp=8", rf_a1); end
      tick();
      idle();
      #2;
      checks++; if (e_rs_val !== 32'h1234) begin failures++; $display("FAIL alu_e_rs got=%h exp=1234", e_rs_val); end
      tick();
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_rf_we got=%0b exp=1", rf_we); end
      checks++; if (rf_a3 !== 5'd8) begin failures++; $display("FAIL alu_rf_a3 got=%0d exp=8", rf_a3); end
   endtask

   task automatic test_load_use();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd8, 2'd2);
      tick();
      issue(5'd8, 2'd1, 5'd0, TUSE_NONE, 1'b1, 5'd11, 2'd1);
      rf_rd1 = 32'h5555; fwd_e = 32'hEEEE; fwd_m = 32'hDDDD; fwd_w = 32'hBEEF;
      #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall_c1 got=%0b exp=1", stall); end
      tick();
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_stall_c2 got=%0b exp=0", stall); end
      tick();
      idle();
      #2;
      checks++; if (e_rs_val !== 32'hBEEF) begin failures++; $display("FAIL lw_e_rs got=%h exp=beef", e_rs_val); end
   endtask

   task automatic test_load_branch();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd8, 2'd2);
      tick();
      issue(5'd8, 2'd0, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0);
      rf_rd1 = 32'h5555; fwd_e = 32'hEEEE; fwd_m = 32'hDDDD; fwd_w = 32'hCAFE;
      #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL beq_stall_c1 got=%0b exp=1", stall); end
      tick();
      #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL beq_stall_c2 got=%0b exp=1", stall); end
      tick();
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL beq_stall_c3 got=%0b exp=0", stall); end
      checks++; if (d_rs_val !== 32'hCAFE) begin failures++; $display("FAIL beq_d_rs got=%h exp=cafe", d_rs_val); end
      tick();
   endtask

   task automatic test_zero_reg();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd2);
      tick();
      issue(5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
      rf_rd1 = 32'h0; rf_rd2 = 32'h0; fwd_e = 32'h77; fwd_m = 32'h66; fwd_w = 32'h55;
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%0b exp=0", stall); end
      checks++; if (d_rs_val !== 32'h0) begin failures++; $display("FAIL zero_d_rs got=%h exp=0", d_rs_val); end
      idle();
      tick();
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_rf_we got=%0b exp=0", rf_we); end
   endtask

   task automatic test_nearest_wins();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd9, 2'd1);
      tick();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd9, 2'd0);
      tick();
      issue(5'd9, 2'd0, 5'd9, 2'd0, 1'b0, 5'd0, 2'd0);
      rf_rd1 = 32'h3333; rf_rd2 = 32'h4444; fwd_e = 32'hA; fwd_m = 32'hB; fwd_w = 32'hC;
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL near_stall got=%0b exp=0", stall); end
      checks++; if (d_rs_val !== 32'hA) begin failures++; $display("FAIL near_d_rs got=%h exp=a", d_rs_val); end
      checks++; if (d_rt_val !== 32'hA) begin failures++; $display("FAIL near_d_rt got=%h exp=a", d_rt_val); end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      flush();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd5, 2'd0);
      tick();
      issue(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd8, 2'd2);
      tick();
      issue(5'd8, 2'd0, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0);
      rf_rd1 = 32'h5555; fwd_e = 32'hEEEE; fwd_m = 32'hDDDD; fwd_w = 32'hCCCC;
      tick();
      #2;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall got=%0b exp=1", stall); end
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL rst_pre_rf_we got=%0b exp=1", rf_we); end
      reset = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we got=%0b exp=0", rf_we); end
      tick();
      reset = 1'b1;
      rf_rd1 = 32'h600D; fwd_e = 32'hBAD1; fwd_m = 32'hBAD2; fwd_w = 32'hBAD3;
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_post_stall got=%0b exp=0", stall); end
      checks++; if (d_rs_val !== 32'h600D) begin failures++; $display("FAIL rst_post_d_rs got=%h exp=600d", d_rs_val); end
      tick();
      idle();
      #2;
      checks++; if (e_rs_val !== 32'h600D) begin failures++; $display("FAIL rst_post_e_rs got=%h exp=600d", e_rs_val); end
   endtask

   initial begin
      test_reset();
      test_alu_fwd_m();
      test_load_use();
      test_load_branch();
      test_zero_reg();
      test_nearest_wins();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
